// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter for the shared parking barrier gate: four level requesters, one commit
// pulse per served request. Define PARKING_ARB_STATS_EN to add saturating served/reject counters.
module parking_gate_arbiter #(
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned OPEN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [CNT_W-1:0] pc,
  input  logic [CNT_W-1:0] upc,
  input  logic [CNT_W-1:0] vs,
  input  logic [CNT_W-1:0] uvs,
  output logic [3:0]       ack,
  output logic [3:0]       reject,
  output logic             ci,
  output logic             uci,
  output logic             ce,
  output logic             uce,
  output logic             gate_open,
  output logic             busy,
`ifdef PARKING_ARB_STATS_EN
  output logic [15:0]      served_cnt,
  output logic [15:0]      reject_cnt,
`endif
  output logic [1:0]       grant_idx
);

  localparam int unsigned TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [TW-1:0] TimerLoad = TW'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StOpen, StClose} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    grant_q, grant_d;
  logic [3:0]    ack_q, ack_d;
  logic [3:0]    reject_q, reject_d;
  logic          gate_q, gate_d;

  logic [3:0] valid;
  logic [3:0] elig;
  logic       exit_pend;
  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;

  assign valid     = {upc != '0, pc != '0, uvs != '0, vs != '0};
  assign exit_pend = req[2] | req[3];
  // Entries that cannot be honoured step aside while an exit (which frees space) waits.
  assign elig      = req & ~({2'b00, ~valid[1:0]} & {4{exit_pend}});

  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    gate_d   = gate_q;
    ack_d    = '0;
    reject_d = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          ptr_d = winner + 2'd1;
          if (valid[winner]) begin
            ack_d   = 4'b0001 << winner;
            gate_d  = 1'b1;
            grant_d = winner;
            timer_d = TimerLoad;
            state_d = StOpen;
          end else begin
            reject_d = 4'b0001 << winner;
          end
        end
      end
      StOpen: begin
        if (timer_q == '0) begin
          gate_d  = 1'b0;
          state_d = StClose;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StClose: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      reject_q <= '0;
      gate_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      reject_q <= reject_d;
      gate_q   <= gate_d;
    end
  end

  assign ack       = ack_q;
  assign reject    = reject_q;
  assign ci        = ack_q[0];
  assign uci       = ack_q[1];
  assign ce        = ack_q[2];
  assign uce       = ack_q[3];
  assign gate_open = gate_q;
  assign busy      = (state_q != StIdle);
  assign grant_idx = grant_q;

`ifdef PARKING_ARB_STATS_EN
  logic [15:0] served_q, rejected_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      served_q   <= '0;
      rejected_q <= '0;
    end else begin
      if (|ack_d && served_q != 16'hFFFF) served_q <= served_q + 16'd1;
      if (|reject_d && rejected_q != 16'hFFFF) rejected_q <= rejected_q + 16'd1;
    end
  end

  assign served_cnt = served_q;
  assign reject_cnt = rejected_q;
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios plus randomized requesters checked
// against a cycle-count reference model of the arbitration rules.
module tb_parking_gate_arbiter;

  localparam int unsigned CNT_W       = 11;
  localparam int unsigned OPEN_CYCLES = 4;
  localparam int          Period      = OPEN_CYCLES + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = '0;
  logic [CNT_W-1:0] pc  = '0;
  logic [CNT_W-1:0] upc = '0;
  logic [CNT_W-1:0] vs  = '0;
  logic [CNT_W-1:0] uvs = '0;
  logic [3:0]       ack, reject;
  logic             ci, uci, ce, uce, gate_open, busy;
  logic [1:0]       grant_idx;
`ifdef PARKING_ARB_STATS_EN
  logic [15:0]      served_cnt, reject_cnt;
`endif

  parking_gate_arbiter #(
    .CNT_W      (CNT_W),
    .OPEN_CYCLES(OPEN_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .pc        (pc),
    .upc       (upc),
    .vs        (vs),
    .uvs       (uvs),
    .ack       (ack),
    .reject    (reject),
    .ci        (ci),
    .uci       (uci),
    .ce        (ce),
    .uce       (uce),
    .gate_open (gate_open),
    .busy      (busy),
`ifdef PARKING_ARB_STATS_EN
    .served_cnt(served_cnt),
    .reject_cnt(reject_cnt),
`endif
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycles until the gate is free again, gate dwell left, RR pointer.
  int         m_ptr, m_free, m_gate_left;
  logic [1:0] m_grant;
  logic [3:0] e_ack, e_rej;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] obs();
    return {ack, reject, uce, ce, uci, ci, gate_open, busy, grant_idx};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_free = 0; m_gate_left = 0; m_grant = '0; e_ack = '0; e_rej = '0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] v);
    logic [3:0] el;
    int         w;
    e_ack = '0;
    e_rej = '0;
    if (m_free == 0) begin
      for (int i = 0; i < 4; i++)
        el[i] = r[i] && !(i < 2 && (r[2] || r[3]) && !v[i]);
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && el[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) begin
        m_ptr = (w + 1) % 4;
        if (v[w]) begin
          e_ack[w]    = 1'b1;
          m_grant     = 2'(w);
          m_gate_left = OPEN_CYCLES;
          m_free      = OPEN_CYCLES + 1;
        end else begin
          e_rej[w] = 1'b1;
        end
      end
    end else begin
      m_free--;
      if (m_gate_left > 0) m_gate_left--;
    end
  endtask

  task automatic test_reset();
    req = '0;
    do_reset();
    if (obs() !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0000", obs());
    end
    n_cmp++;
    if (busy !== 1'b0 || gate_open !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy_gate: got busy=%b gate=%b want 0/0", busy, gate_open);
    end
    n_cmp++;
  endtask

  task automatic test_single_entry();
    logic [15:0] exp;
    do_reset();
    vs = 11'd5; uvs = '0; pc = '0; upc = '0;
    req = 4'b0001;
    for (int e = 0; e < 7; e++) begin
      tick();
      if (e == 0) req = '0;
      exp = {(e == 0) ? 4'b0001 : 4'b0000, 4'b0000, (e == 0) ? 4'b0001 : 4'b0000,
             1'(e < 4), 1'(e < 5), 2'd0};
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL single_entry e=%0d: got %h want %h", e, obs(), exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp;
    logic [3:0]  a;
    do_reset();
    vs = 11'd5; uvs = 11'd5; pc = 11'd5; upc = 11'd5;
    req = 4'b1111;
    for (int e = 0; e < 4 * Period; e++) begin
      tick();
      a   = (e % Period == 0) ? (4'b0001 << (e / Period)) : 4'b0000;
      exp = {a, 4'b0000, a, 1'((e % Period) < 4), 1'((e % Period) < 5), 2'(e / Period)};
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL round_robin e=%0d: got %h want %h", e, obs(), exp);
      end
      n_cmp++;
    end
    req = '0;
  endtask

  task automatic test_reject();
    logic [15:0] exp;
    do_reset();
    vs = '0; pc = '0; uvs = '0; upc = '0;
    req = 4'b0001;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (e == 0) req = '0;
      exp = {4'b0000, (e == 0) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL reject_entry e=%0d: got %h want %h", e, obs(), exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_exit_priority();
    logic [15:0] exp;
    logic [3:0]  a;
    do_reset();
    vs = '0; pc = 11'd3; uvs = '0; upc = '0;
    req = 4'b0101;
    for (int e = 0; e <= Period; e++) begin
      tick();
      if (e == 0) begin
        req[2] = 1'b0;
        vs     = 11'd1;
      end
      if (e == Period) req[0] = 1'b0;
      a   = (e == 0) ? 4'b0100 : (e == Period) ? 4'b0001 : 4'b0000;
      exp = {a, 4'b0000, a, 1'((e % Period) < 4), 1'((e % Period) < 5),
             (e < Period) ? 2'd2 : 2'd0};
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL exit_priority e=%0d: got %h want %h", e, obs(), exp);
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    vs = 11'd5; pc = '0; uvs = '0; upc = '0;
    req = 4'b0001;
    tick();
    req = '0;
    if (ci !== 1'b1 || gate_open !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_grant: got ci=%b gate=%b want 1/1", ci, gate_open);
    end
    n_cmp++;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (obs() !== 16'h0) begin
      n_err++;
      $display("FAIL midrst_clear: got %h want 0000", obs());
    end
    n_cmp++;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (ci !== 1'b0 || gate_open !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_quiet e=%0d: got ci=%b gate=%b busy=%b want 0/0/0",
                 e, ci, gate_open, busy);
      end
      n_cmp++;
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    logic [3:0]  v;
    do_reset();
    model_reset();
    req = '0;
    vs = 11'd2; uvs = 11'd1; pc = 11'd1; upc = 11'd0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        vs  = CNT_W'($urandom_range(0, 2));
        uvs = CNT_W'($urandom_range(0, 2));
        pc  = CNT_W'($urandom_range(0, 2));
        upc = CNT_W'($urandom_range(0, 2));
      end
      rst = ($urandom_range(0, 99) == 0);
      v   = {upc != '0, pc != '0, uvs != '0, vs != '0};
      if (rst) model_reset();
      else model_edge(req, v);
      tick();
      exp = {e_ack, e_rej, e_ack, 1'(m_gate_left > 0), 1'(m_free > 0), m_grant};
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL random c=%0d: got %h want %h", c, obs(), exp);
      end
      n_cmp++;
      for (int i = 0; i < 4; i++) begin
        if (e_ack[i] || e_rej[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
    end
    rst = 1'b0;
    req = '0;
  endtask

`ifdef PARKING_ARB_STATS_EN
  task automatic test_stats();
    logic [3:0] seq [4];
    seq[0] = 4'b0100; seq[1] = 4'b0001; seq[2] = 4'b0010; seq[3] = 4'b0001;
    do_reset();
    vs = 11'd5; uvs = 11'd5; pc = '0; upc = '0;
    for (int s = 0; s < 4; s++) begin
      req = seq[s];
      tick();
      req = '0;
      for (int e = 0; e < Period; e++) tick();
    end
    if (served_cnt !== 16'd3 || reject_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL stats: got served=%0d rejected=%0d want 3/1", served_cnt, reject_cnt);
    end
    n_cmp++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_entry();
    test_round_robin();
    test_reject();
    test_exit_priority();
    test_reset_mid_open();
    test_random();
`ifdef PARKING_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
